pwm_capture: RTL and testbench

Measures an incoming single-bit PWM waveform, reporting high time and period in `clk` cycles once per PWM period. It sits on the receive side of a PWM link and returns the duty information a PWM generator encodes. Typical uses are loopback checking of generated PWM and reading external PWM sensors. The input is asynchronous and is synchronized internally. Inputs that stop toggling are flagged as stuck after a timeout.

---
 rtl/pwm_pkg.sv | 11 +
 rtl/pwm_sync.sv | 29 ++
 rtl/pwm_capture.sv | 122 ++++++++++++
 tb/tb_pwm_capture.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM capture block: FSM states and default counter width.
package pwm_pkg;

    localparam int PWM_CNT_W = 11;

    typedef enum logic {
        IDLE = 1'b0,
        MEAS = 1'b1
    } state_e;

endpackage

// File: rtl/pwm_sync.sv
// Two-flop synchronizer plus a delay flop for any asynchronous single-bit input.
// Provides the synchronized level and a one-cycle rising-edge strobe.
module pwm_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic s,
    output logic rise
);

    logic meta;
    logic s_d;

    // NOTE: non-blocking assignments so every flop samples its pre-edge input; blocking would collapse the chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            s    <= 1'b0;
            s_d  <= 1'b0;
        end else begin
            meta <= din;
            s    <= meta;
            s_d  <= s;
        end
    end

    assign rise = s & ~s_d;

endmodule

// File: rtl/pwm_capture.sv
// Measures high time and period of an asynchronous PWM input, one result per period,
// rejecting short glitch periods and flagging an input that stops toggling.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int CNT_W      = PWM_CNT_W,
    parameter int MIN_PERIOD = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             PWM_in,
    output logic [CNT_W-1:0] high_out,
    output logic [CNT_W-1:0] period_out,
    output logic             meas_vld,
    output logic             glitch_err,
    output logic             stuck,
    output logic             stuck_lvl
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MIN = CNT_W'(MIN_PERIOD);

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] per_cnt;
    logic [CNT_W-1:0] hi_cnt;
    logic             s;
    logic             rise;

    logic             timeout;
    logic             meas_ok;
    logic             glitch;

    logic [CNT_W-1:0] high_d;
    logic [CNT_W-1:0] period_d;
    logic             vld_d;
    logic             glitch_d;
    logic             stuck_d;
    logic             lvl_d;

    pwm_sync u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (PWM_in),
        .s    (s),
        .rise (rise)
    );

    // A rise coinciding with saturation wins over the timeout.
    assign timeout = (per_cnt == CNT_MAX) && !rise;
    assign meas_ok = rise && (state_q == MEAS) && (per_cnt >= CNT_MIN);
    assign glitch  = rise && (state_q == MEAS) && (per_cnt < CNT_MIN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (rise)    state_d = MEAS;
            MEAS:    if (timeout) state_d = IDLE;
            default:              state_d = IDLE;
        endcase
    end

    // NOTE: every output gets a default before the branches so no path leaves it unassigned (no latch).
    always_comb begin
        high_d   = high_out;
        period_d = period_out;
        vld_d    = 1'b0;
        glitch_d = 1'b0;
        stuck_d  = stuck;
        lvl_d    = stuck_lvl;
        if (meas_ok) begin
            high_d   = hi_cnt;
            period_d = per_cnt;
            vld_d    = 1'b1;
            stuck_d  = 1'b0;
        end else if (glitch) begin
            glitch_d = 1'b1;
        end else if (timeout) begin
            stuck_d  = 1'b1;
            lvl_d    = s;
            high_d   = s ? CNT_MAX : '0;
            period_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            per_cnt    <= '0;
            hi_cnt     <= '0;
            high_out   <= '0;
            period_out <= '0;
            meas_vld   <= 1'b0;
            glitch_err <= 1'b0;
            stuck      <= 1'b0;
            stuck_lvl  <= 1'b0;
        end else begin
            if (rise) begin
                per_cnt <= CNT_ONE;
                hi_cnt  <= CNT_ONE;
            end else if (timeout) begin
                per_cnt <= '0;
                hi_cnt  <= '0;
            end else begin
                if (per_cnt != CNT_MAX)      per_cnt <= per_cnt + CNT_ONE;
                if (s && hi_cnt != CNT_MAX)  hi_cnt  <= hi_cnt + CNT_ONE;
            end
            high_out   <= high_d;
            period_out <= period_d;
            meas_vld   <= vld_d;
            glitch_err <= glitch_d;
            stuck      <= stuck_d;
            stuck_lvl  <= lvl_d;
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: PWM waveforms are built from high/low run lengths and
// the expected measurement/glitch events are derived from rise-to-rise arithmetic on those runs.
module tb_pwm_capture;

    localparam int CNT_W      = 11;
    localparam int MIN_PERIOD = 4;
    localparam int CNT_MAX    = (1 << CNT_W) - 1;

    typedef struct packed {
        int   cyc;
        logic glitch;
        int   hi;
        int   per;
    } ev_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             PWM_in;
    logic [CNT_W-1:0] high_out;
    logic [CNT_W-1:0] period_out;
    logic             meas_vld;
    logic             glitch_err;
    logic             stuck;
    logic             stuck_lvl;

    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    ev_t  exp_q[$];
    ev_t  obs_q[$];

    // Reference model state: whether a previous rise is known, when it was, and high cycles since.
    logic armed     = 1'b0;
    logic last_in   = 1'b0;
    int   last_rise = 0;
    int   hi_acc    = 0;
    int   last_hi   = 0;
    int   last_per  = 0;

    pwm_capture #(.CNT_W(CNT_W), .MIN_PERIOD(MIN_PERIOD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .PWM_in    (PWM_in),
        .high_out  (high_out),
        .period_out(period_out),
        .meas_vld  (meas_vld),
        .glitch_err(glitch_err),
        .stuck     (stuck),
        .stuck_lvl (stuck_lvl)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (meas_vld)   obs_q.push_back('{cyc, 1'b0, int'(high_out), int'(period_out)});
            if (glitch_err) obs_q.push_back('{cyc, 1'b1, 0, 0});
        end
    end

    function automatic string ev_str(ev_t e);
        return $sformatf("cyc=%0d glitch=%0b hi=%0d per=%0d", e.cyc, e.glitch, e.hi, e.per);
    endfunction

    // A rise driven at cycle k is seen by the DUT two edges later and reported at k+3.
    // Rises further apart than the saturation count mean the input timed out in between.
    task automatic note_rise();
        int per;
        per = cyc - last_rise;
        if (armed && per <= CNT_MAX) begin
            if (per < MIN_PERIOD) begin
                exp_q.push_back('{cyc + 3, 1'b1, 0, 0});
            end else begin
                exp_q.push_back('{cyc + 3, 1'b0, hi_acc, per});
                last_hi  = hi_acc;
                last_per = per;
            end
        end
        armed     = 1'b1;
        last_rise = cyc;
        hi_acc    = 0;
    endtask

    task automatic drive(input logic v, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (v && !last_in) note_rise();
            PWM_in  = v;
            last_in = v;
            if (v) hi_acc++;
        end
    endtask

    task automatic model_reset();
        armed   = 1'b0;
        last_in = 1'b0;
        hi_acc  = 0;
    endtask

    task automatic test_reset();
        #1;
        checks += 6;
        if (high_out !== '0)    begin errors++; $display("FAIL reset_high: got %0d, expected 0", high_out); end
        if (period_out !== '0)  begin errors++; $display("FAIL reset_period: got %0d, expected 0", period_out); end
        if (meas_vld !== 1'b0)  begin errors++; $display("FAIL reset_vld: got %b, expected 0", meas_vld); end
        if (glitch_err !== 1'b0) begin errors++; $display("FAIL reset_glitch: got %b, expected 0", glitch_err); end
        if (stuck !== 1'b0)     begin errors++; $display("FAIL reset_stuck: got %b, expected 0", stuck); end
        if (stuck_lvl !== 1'b0) begin errors++; $display("FAIL reset_lvl: got %b, expected 0", stuck_lvl); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_steady();
        drive(0, 10);
        for (int p = 0; p < 3; p++) begin
            drive(1, 513);
            drive(0, 511);
        end
        drive(0, 20);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL steady_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL steady_ev%0d: got %s, expected %s", i, ev_str(obs_q[i]), ev_str(exp_q[i]));
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_duty_change();
        drive(1, 100); drive(0, 924);
        drive(1, 100); drive(0, 924);
        drive(1, 900); drive(0, 124);
        drive(1, 900); drive(0, 124);
        drive(1, 5);   drive(0, 10);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL duty_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL duty_ev%0d: got %s, expected %s", i, ev_str(obs_q[i]), ev_str(exp_q[i]));
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_glitch();
        drive(1, 400); drive(0, 624);
        drive(1, 1);   drive(0, 1);
        drive(1, 4);
        checks++;
        if (glitch_err !== 1'b1 || int'(high_out) != last_hi || int'(period_out) != last_per) begin
            errors++;
            $display("FAIL glitch_hold: got glitch=%b hi=%0d per=%0d, expected glitch=1 hi=%0d per=%0d",
                     glitch_err, high_out, period_out, last_hi, last_per);
        end
        drive(1, 596); drive(0, 424);
        drive(1, 2);   drive(0, 1);
        drive(1, 2);   drive(0, 2);
        drive(1, 3);   drive(0, 10);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL glitch_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL glitch_ev%0d: got %s, expected %s", i, ev_str(obs_q[i]), ev_str(exp_q[i]));
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_random();
        int h;
        int l;
        for (int p = 0; p < 25; p++) begin
            if ($urandom_range(0, 4) == 0) begin
                h = $urandom_range(1, 2);
                l = $urandom_range(1, 3);
            end else begin
                h = $urandom_range(1, 300);
                l = $urandom_range(1, 300);
            end
            drive(1, h);
            drive(0, l);
        end
        drive(1, 3); drive(0, 10);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL random_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL random_ev%0d: got %s, expected %s", i, ev_str(obs_q[i]), ev_str(exp_q[i]));
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_stuck_low();
        int k0;
        drive(1, 300); drive(0, 300);
        drive(1, 250);
        k0 = last_rise;
        while (cyc < k0 + CNT_MAX + 2) drive(0, 1);
        checks++;
        if (stuck !== 1'b0) begin errors++; $display("FAIL stuck_low_early: got %b, expected 0", stuck); end
        drive(0, 1);
        checks++;
        if (stuck !== 1'b1 || stuck_lvl !== 1'b0 || high_out !== '0 || period_out !== '0) begin
            errors++;
            $display("FAIL stuck_low: got stuck=%b lvl=%b hi=%0d per=%0d, expected stuck=1 lvl=0 hi=0 per=0",
                     stuck, stuck_lvl, high_out, period_out);
        end
        drive(0, 5);
        drive(1, 200); drive(0, 200);
        checks++;
        if (stuck !== 1'b1) begin errors++; $display("FAIL stuck_low_partial: got %b, expected 1", stuck); end
        drive(1, 100); drive(0, 10);
        checks++;
        if (stuck !== 1'b0) begin errors++; $display("FAIL stuck_low_clear: got %b, expected 0", stuck); end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL stuck_low_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL stuck_low_ev%0d: got %s, expected %s", i, ev_str(obs_q[i]), ev_str(exp_q[i]));
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_stuck_high();
        int k0;
        drive(1, 300); drive(0, 300);
        drive(1, 1);
        k0 = last_rise;
        while (cyc < k0 + CNT_MAX + 2) drive(1, 1);
        checks++;
        if (stuck !== 1'b0) begin errors++; $display("FAIL stuck_high_early: got %b, expected 0", stuck); end
        drive(1, 1);
        checks++;
        if (stuck !== 1'b1 || stuck_lvl !== 1'b1 || int'(high_out) != CNT_MAX || period_out !== '0) begin
            errors++;
            $display("FAIL stuck_high: got stuck=%b lvl=%b hi=%0d per=%0d, expected stuck=1 lvl=1 hi=%0d per=0",
                     stuck, stuck_lvl, high_out, period_out, CNT_MAX);
        end
        drive(0, 50);
        drive(1, 100); drive(0, 100);
        drive(1, 100); drive(0, 10);
        checks++;
        if (stuck !== 1'b0) begin errors++; $display("FAIL stuck_high_clear: got %b, expected 0", stuck); end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL stuck_high_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL stuck_high_ev%0d: got %s, expected %s", i, ev_str(obs_q[i]), ev_str(exp_q[i]));
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_mid_reset();
        drive(1, 200); drive(0, 200);
        drive(1, 150); drive(0, 100);
        @(negedge clk);
        rst_n  = 1'b0;
        PWM_in = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({high_out, period_out, meas_vld, glitch_err, stuck, stuck_lvl} !== '0) begin
            errors++;
            $display("FAIL mid_reset: got hi=%0d per=%0d vld=%b glitch=%b stuck=%b lvl=%b, expected all 0",
                     high_out, period_out, meas_vld, glitch_err, stuck, stuck_lvl);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        drive(0, 5);
        drive(1, 100); drive(0, 100);
        drive(1, 50);  drive(0, 10);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL mid_reset_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL mid_reset_ev%0d: got %s, expected %s", i, ev_str(obs_q[i]), ev_str(exp_q[i]));
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_latency();
        drive(1, 1);    drive(0, 9);
        drive(1, 1000); drive(0, CNT_MAX - 1001);
        drive(1, 1000); drive(0, CNT_MAX - 1000);
        drive(1, 5);    drive(0, 10);
        checks++;
        if (stuck !== 1'b0) begin errors++; $display("FAIL latency_stuck: got %b, expected 0", stuck); end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL latency_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL latency_ev%0d: got %s, expected %s", i, ev_str(obs_q[i]), ev_str(exp_q[i]));
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    initial begin
        rst_n  = 1'b0;
        PWM_in = 1'b0;
        test_reset();
        test_steady();
        test_duty_change();
        test_glitch();
        test_random();
        test_stuck_low();
        test_stuck_high();
        test_mid_reset();
        test_latency();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
